// File: rtl/weight_fetch_ctrl_if.sv
// Stream/memory bundle for weight_fetch_ctrl: layer-input sample stream,
// weight BRAM read port and the aligned {sample, weight} output stream.
// master = the fetch controller side, slave = its environment.
interface weight_fetch_ctrl_if #(
  parameter int addressWidth = 10,
  parameter int dataWidth    = 16
);
  logic                   in_valid;
  logic [dataWidth-1:0]   in_data;
  logic                   ready;
  logic                   w_ren;
  logic [addressWidth:0]  w_raddr;
  logic [dataWidth-1:0]   w_rdata;
  logic                   out_valid;
  logic [dataWidth-1:0]   out_data;
  logic [dataWidth-1:0]   out_weight;
  logic                   out_last;

  modport master (
    input  in_valid, in_data, w_rdata,
    output ready, w_ren, w_raddr, out_valid, out_data, out_weight, out_last
  );

  modport slave (
    output in_valid, in_data, w_rdata,
    input  ready, w_ren, w_raddr, out_valid, out_data, out_weight, out_last
  );
endinterface

// File: rtl/weight_fetch_ctrl.sv
// weight_fetch_ctrl: sequences one neuron's weight memory for one pass.
// Each accepted sample issues a BRAM read; the sample is delayed one cycle
// so it lines up with the returned weight for the MAC stage.
// Optional build macro WFETCH_STATUS_EN adds the sticky overrun_err flag.
module weight_fetch_ctrl #(
  parameter int numWeight    = 784,
  parameter int addressWidth = 10,
  parameter int dataWidth    = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   clear,
  weight_fetch_ctrl_if.master    bus,
  output logic                   busy,
  output logic                   done
`ifdef WFETCH_STATUS_EN
  ,
  output logic                   overrun_err
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [addressWidth-1:0] LAST_ADDR = addressWidth'(numWeight - 1);

  state_t                  state_q, state_d;
  logic [addressWidth-1:0] addr_q, addr_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_last_q, out_last_d;
  logic [dataWidth-1:0]    out_data_q, out_data_d;
  logic                    ready_c;
  logic                    accept_c;

  // Next-state, address sequencing and align-stage loading
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    ready_c     = 1'b0;
    accept_c    = 1'b0;
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;
    out_data_d  = out_data_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          addr_d  = '0;
        end
      end
      S_RUN: begin
        ready_c = 1'b1;
        if (bus.in_valid) begin
          accept_c    = 1'b1;
          out_valid_d = 1'b1;
          out_data_d  = bus.in_data;
          out_last_d  = (addr_q == LAST_ADDR);
          if (addr_q == LAST_ADDR) begin
            state_d = S_DRAIN;
            addr_d  = '0;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // clear overrides everything above; a read issued last cycle still
    // completes through the already-loaded align stage
    if (clear) begin
      state_d     = S_IDLE;
      addr_d      = '0;
      ready_c     = 1'b0;
      accept_c    = 1'b0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      out_data_d  = out_data_q;
    end
  end

  // State, address and align-stage registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.ready      = ready_c;
  assign bus.w_ren      = accept_c;
  assign bus.w_raddr    = {1'b0, addr_q};
  assign bus.out_valid  = out_valid_q;
  assign bus.out_last   = out_last_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_weight = bus.w_rdata;
  assign busy           = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done           = (state_q == S_DONE);

`ifdef WFETCH_STATUS_EN
  logic overrun_q, overrun_d;
  logic start_ok;

  // Sticky dropped-sample flag; a new drop in the start cycle wins
  always_comb begin
    start_ok  = (state_q == S_IDLE) && start && !clear;
    overrun_d = (overrun_q && !start_ok) || (bus.in_valid && !ready_c);
  end

  // Overrun flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overrun_q <= 1'b0;
    else        overrun_q <= overrun_d;
  end

  assign overrun_err = overrun_q;
`endif

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Self-checking bench for weight_fetch_ctrl: directed scenarios followed by
// randomized start/clear/in_valid traffic, compared against a pass-level
// reference model and a behavioural 1-cycle-latency weight BRAM.
module tb_weight_fetch_ctrl;
  localparam int NW = 4;
  localparam int AW = 2;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic clear = 1'b0;
  logic busy, done;
`ifdef WFETCH_STATUS_EN
  logic overrun_err;
`endif

  weight_fetch_ctrl_if #(.addressWidth(AW), .dataWidth(DW)) bus ();

  weight_fetch_ctrl #(.numWeight(NW), .addressWidth(AW), .dataWidth(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .clear (clear),
    .bus   (bus),
    .busy  (busy),
    .done  (done)
`ifdef WFETCH_STATUS_EN
    ,
    .overrun_err (overrun_err)
`endif
  );

  always #5 clk = ~clk;

  // behavioural weight memory, 1-cycle read latency
  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] wr;
  assign bus.w_rdata = wr;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) wr <= '0;
    else if (bus.w_ren) wr <= mem[bus.w_raddr[AW-1:0]];

  int total = 0;
  int bad = 0;

  // reference model: pass phase, samples taken this pass, last emitted pair
  int m_mode;          // 0 idle, 1 accepting, 2 final read in flight, 3 done pulse
  int m_cnt;
  bit m_pv, m_pl, m_ovr;
  logic [DW-1:0] m_pd, m_pw;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_pv = 0; m_pl = 0; m_ovr = 0; m_pd = '0; m_pw = '0;
  endtask

  // one clock: drive at posedge+1, check at negedge, advance model after edge
  task automatic step(input bit s, input bit c, input bit v, input logic [DW-1:0] d);
    bit re, we, so;
    start = s; clear = c; bus.in_valid = v; bus.in_data = d;
    @(negedge clk);
    re = (m_mode == 1) && !c;
    we = re && v;
    chk("ready",     32'(bus.ready),     32'(re));
    chk("w_ren",     32'(bus.w_ren),     32'(we));
    chk("w_raddr",   32'(bus.w_raddr),   32'(m_cnt));
    chk("out_valid", 32'(bus.out_valid), 32'(m_pv));
    chk("out_last",  32'(bus.out_last),  32'(m_pl));
    chk("out_data",  32'(bus.out_data),  32'(m_pd));
    if (m_pv) chk("out_weight", 32'(bus.out_weight), 32'(m_pw));
    chk("busy",      32'(busy),          32'(m_mode == 1 || m_mode == 2));
    chk("done",      32'(done),          32'(m_mode == 3));
`ifdef WFETCH_STATUS_EN
    chk("overrun_err", 32'(overrun_err), 32'(m_ovr));
`endif
    @(posedge clk);
    #1;
    so    = (m_mode == 0) && s && !c;
    m_ovr = (m_ovr && !so) || (v && !re);
    m_pv  = we;
    m_pl  = we && (m_cnt == NW - 1);
    if (we) begin
      m_pd = d;
      m_pw = mem[m_cnt];
    end
    if (c) begin
      m_mode = 0; m_cnt = 0;
    end else begin
      case (m_mode)
        0: if (s) begin m_mode = 1; m_cnt = 0; end
        1: if (v) begin
             if (m_cnt == NW - 1) begin m_mode = 2; m_cnt = 0; end
             else m_cnt++;
           end
        2: m_mode = 3;
        default: m_mode = 0;
      endcase
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0);
  endtask

  initial begin
    int dens;
    logic [DW-1:0] dv;
    bit pat [7] = '{1, 0, 0, 1, 1, 0, 1};
    for (int i = 0; i < 2**AW; i++) mem[i] = DW'($urandom);
    bus.in_valid = 1'b0; bus.in_data = '0;
    model_reset();
    #12;
    chk("rst_ready", 32'(bus.ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // four consecutive samples 1..4
    step(1, 0, 0, '0);
    for (int i = 1; i <= 4; i++) step(0, 0, 1, DW'(i));
    idle(3);

    // gappy in_valid
    step(1, 0, 0, '0);
    for (int i = 0; i < 7; i++) step(0, 0, pat[i], DW'(16 + i));
    idle(3);

    // start mid-pass ignored, then back-to-back second pass
    step(1, 0, 0, '0);
    step(0, 0, 1, 8'h21);
    step(1, 0, 1, 8'h22);
    step(1, 0, 0, '0);
    step(0, 0, 1, 8'h23);
    step(0, 0, 1, 8'h24);
    step(0, 0, 0, '0);
    step(0, 0, 0, '0);
    step(1, 0, 0, '0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, DW'(8'h30 + i));
    idle(3);

    // clear after two accepts, then a fresh pass
    step(1, 0, 0, '0);
    step(0, 0, 1, 8'h41);
    step(0, 0, 1, 8'h42);
    step(0, 1, 1, 8'h43);
    idle(2);
    step(1, 0, 0, '0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, DW'(8'h50 + i));
    idle(3);

    // dropped samples while idle, then a pass, then start clears the flag
    step(0, 0, 1, 8'h61);
    step(0, 0, 0, '0);
    step(1, 0, 0, '0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, DW'(8'h70 + i));
    idle(3);

    // randomized traffic
    dens = 50;
    for (int n = 0; n < 1500; n++) begin
      if (n % 200 == 0) dens = $urandom_range(10, 100);
      if (m_mode == 0 && $urandom_range(0, 3) == 0)
        for (int i = 0; i < 2**AW; i++) mem[i] = DW'($urandom);
      dv = DW'($urandom);
      step($urandom_range(0, 7) == 0, $urandom_range(0, 59) == 0,
           $urandom_range(1, 100) <= dens, dv);
    end
    idle(4);

    // asynchronous reset in the middle of a pass
    step(1, 0, 0, '0);
    step(0, 0, 1, 8'h81);
    start = 1'b0; clear = 1'b0; bus.in_valid = 1'b1; bus.in_data = 8'h82;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ready",     32'(bus.ready),     32'd0);
    chk("arst_w_ren",     32'(bus.w_ren),     32'd0);
    chk("arst_w_raddr",   32'(bus.w_raddr),   32'd0);
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_out_last",  32'(bus.out_last),  32'd0);
    chk("arst_out_data",  32'(bus.out_data),  32'd0);
    chk("arst_busy",      32'(busy),          32'd0);
    chk("arst_done",      32'(done),          32'd0);
`ifdef WFETCH_STATUS_EN
    chk("arst_overrun",   32'(overrun_err),   32'd0);
`endif
    bus.in_valid = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
    step(0, 0, 0, '0);
    step(1, 0, 0, '0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, DW'(8'h90 + i));
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // global watchdog so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
